// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: counts rising edges of the neuron spike line over a
// programmable window of clock cycles. At the end of each window it reports
// the count with a one-cycle strobe and updates an exponentially smoothed
// rate. Back-to-back windows run without a gap while enabled.
//
// Output handshake: rate_valid is a pure one-cycle strobe with no ready/back
// pressure. When rate_valid is high, rate, rate_avg and saturated hold the
// result of the window that ended on the previous cycle. They keep that value
// until the next strobe or reset. A consumer must capture them on the strobe
// or read the held values later.
module spike_rate_decoder #(
    parameter int CNT_WIDTH = 8,
    parameter int WIN_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 spike_in,
    input  logic [WIN_WIDTH-1:0] window_len,
    output logic [CNT_WIDTH-1:0] rate,
    output logic                 rate_valid,
    output logic [CNT_WIDTH-1:0] rate_avg,
    output logic                 saturated,
    output logic                 busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t state;
    state_t state_next;

    logic                 spike_q;
    logic                 spike_edge;
    logic [WIN_WIDTH-1:0] win_cnt;
    logic [CNT_WIDTH-1:0] spike_cnt;
    logic                 sat_flag;
    logic                 first_done;

    // Control decisions from the next-state logic.
    logic                 win_load;
    logic                 win_done;

    // Count and sticky flag including this cycle's edge.
    logic [CNT_WIDTH-1:0] final_cnt;
    logic                 final_sat;

    // Smoothing arithmetic in signed CNT_WIDTH+1 bits.
    logic signed [CNT_WIDTH:0] avg_ext;
    logic signed [CNT_WIDTH:0] avg_diff;
    logic signed [CNT_WIDTH:0] avg_step;
    logic signed [CNT_WIDTH:0] avg_sum;
    logic [CNT_WIDTH-1:0]      avg_next;

    // A level that is already high when COUNT starts is not a new spike,
    // because spike_q tracks the line in every state.
    assign spike_edge = spike_in & ~spike_q;

    assign busy = (state == COUNT);

    // Saturating count and sticky saturation flag for the current cycle.
    always_comb begin
        final_cnt = spike_cnt;
        final_sat = sat_flag;
        if (spike_edge) begin
            if (spike_cnt == CNT_MAX) begin
                final_sat = 1'b1;
            end else begin
                final_cnt = spike_cnt + 1'b1;
            end
        end
    end

    // Smoothed rate: avg + floor((count - avg) / 4). The arithmetic shift
    // rounds toward minus infinity, and the result stays in 0..CNT_MAX.
    always_comb begin
        avg_ext  = signed'({1'b0, rate_avg});
        avg_diff = signed'({1'b0, final_cnt}) - avg_ext;
        avg_step = avg_diff >>> 2;
        avg_sum  = avg_ext + avg_step;
        avg_next = first_done ? avg_sum[CNT_WIDTH-1:0] : final_cnt;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. It also decides window (re)load and completion.
    always_comb begin
        state_next = state;
        win_load   = 1'b0;
        win_done   = 1'b0;
        case (state)
            IDLE: begin
                if (ena && (window_len != '0)) begin
                    state_next = COUNT;
                    win_load   = 1'b1;
                end
            end
            COUNT: begin
                if (!ena) begin
                    // Abort: the partial window is dropped and no strobe is sent.
                    state_next = IDLE;
                end else if (win_cnt == '0) begin
                    win_done = 1'b1;
                    if (window_len != '0) begin
                        state_next = COUNT;
                        win_load   = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: edge history, window counters and published results.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            spike_q    <= 1'b0;
            win_cnt    <= '0;
            spike_cnt  <= '0;
            sat_flag   <= 1'b0;
            first_done <= 1'b0;
            rate       <= '0;
            rate_avg   <= '0;
            saturated  <= 1'b0;
            rate_valid <= 1'b0;
        end else begin
            spike_q    <= spike_in;
            rate_valid <= 1'b0;

            if (win_load) begin
                // window_len is sampled only here, so a change in mid-window
                // applies to the next window.
                win_cnt   <= window_len - 1'b1;
                spike_cnt <= '0;
                sat_flag  <= 1'b0;
            end else if (state == COUNT) begin
                spike_cnt <= final_cnt;
                sat_flag  <= final_sat;
                if (win_cnt != '0) begin
                    win_cnt <= win_cnt - 1'b1;
                end
            end

            if (win_done) begin
                rate       <= final_cnt;
                saturated  <= final_sat;
                rate_avg   <= avg_next;
                rate_valid <= 1'b1;
                first_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Testbench for spike_rate_decoder. Directed windows come first, then a
// randomized phase. A window-level reference model pushes each expected
// strobe (cycle, rate, avg, saturated) into a queue. A monitor pops the queue
// and compares whenever the DUT raises rate_valid.
module tb_spike_rate_decoder;

  localparam int CW   = 4;
  localparam int WW   = 8;
  localparam int CMAX = (1 << CW) - 1;
  localparam int EW   = 32 + 1 + CW + CW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n      = 1'b0;
  logic          ena        = 1'b1;
  logic          spike_in   = 1'b1;
  logic [WW-1:0] window_len = 8'd10;

  logic [CW-1:0] rate;
  logic          rate_valid;
  logic [CW-1:0] rate_avg;
  logic          saturated;
  logic          busy;

  spike_rate_decoder #(
    .CNT_WIDTH(CW),
    .WIN_WIDTH(WW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .spike_in  (spike_in),
    .window_len(window_len),
    .rate      (rate),
    .rate_valid(rate_valid),
    .rate_avg  (rate_avg),
    .saturated (saturated),
    .busy      (busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  // Expected strobes: {cycle[31:0], saturated, rate_avg, rate}.
  logic [EW-1:0] exp_q[$];

  // ---------------- reference model (window level) ----------------
  bit m_active     = 1'b0;
  int m_left       = 0;
  int m_edges      = 0;     // true number of edges, never clipped
  int m_avg        = 0;
  bit m_first_done = 1'b0;
  bit m_prev       = 1'b0;
  bit exp_busy     = 1'b0;

  function automatic int floor_div4(input int d);
    if (d >= 0) return d / 4;
    return -((3 - d) / 4);
  endfunction

  // Apply the rules to the inputs that the next rising edge samples.
  task automatic model_step();
    int e;
    int c;
    int a;
    bit s;
    if (!rst_n) begin
      m_active     = 1'b0;
      m_left       = 0;
      m_edges      = 0;
      m_avg        = 0;
      m_first_done = 1'b0;
      m_prev       = 1'b0;
    end else begin
      e      = (spike_in && !m_prev) ? 1 : 0;
      m_prev = spike_in;
      if (!m_active) begin
        if (ena && window_len != 0) begin
          m_active = 1'b1;
          m_left   = window_len;
          m_edges  = 0;
        end
      end else if (!ena) begin
        m_active = 1'b0;
      end else begin
        m_edges += e;
        m_left--;
        if (m_left == 0) begin
          c = (m_edges > CMAX) ? CMAX : m_edges;
          s = (m_edges > CMAX);
          a = m_first_done ? m_avg + floor_div4(c - m_avg) : c;
          m_avg        = a;
          m_first_done = 1'b1;
          exp_q.push_back({32'(cyc + 1), s, a[CW-1:0], c[CW-1:0]});
          if (window_len != 0) begin
            m_left  = window_len;
            m_edges = 0;
          end else begin
            m_active = 1'b0;
          end
        end
      end
    end
    exp_busy = m_active;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit r, input bit e, input int wl, input bit s);
    @(negedge clk);
    rst_n      = r;
    ena        = e;
    window_len = WW'(wl);
    spike_in   = s;
    model_step();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [EW-1:0] ex;
    forever begin
      @(posedge clk);
      #1;
      check("busy", int'(busy), int'(exp_busy));
      if (rate_valid) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL strobe: got unexpected rate_valid, required none (cycle %0d)", cyc);
        end else begin
          vectors--;
          ex = exp_q.pop_front();
          check("strobe_cycle", cyc, int'(ex[EW-1 -: 32]));
          check("rate", int'(rate), int'(ex[CW-1:0]));
          check("rate_avg", int'(rate_avg), int'(ex[2*CW-1 -: CW]));
          check("saturated", int'(saturated), int'(ex[2*CW]));
        end
      end else if (exp_q.size() != 0 && int'(exp_q[0][EW-1 -: 32]) <= cyc) begin
        ex = exp_q.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL strobe: got no rate_valid, required one at cycle %0d", int'(ex[EW-1 -: 32]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int wl_r;
    bit r_r;
    bit e_r;

    // Reset for two edges with the spike held high and ena high.
    drive(1'b0, 1'b1, 10, 1'b1);
    check("reset_rate", int'(rate), 0);
    check("reset_valid", int'(rate_valid), 0);
    check("reset_avg", int'(rate_avg), 0);
    check("reset_sat", int'(saturated), 0);
    check("reset_busy", int'(busy), 0);

    drive(1'b1, 1'b0, 10, 1'b1);
    drive(1'b1, 1'b0, 10, 1'b0);

    // Window 1: length 10, pulses on cycles 0, 3, 6 and 9.
    drive(1'b1, 1'b1, 10, 1'b0);
    for (int j = 0; j < 10; j++) drive(1'b1, 1'b1, 10, (j % 3) == 0);
    check("w1_valid", int'(rate_valid), 1);
    check("w1_rate", int'(rate), 4);
    check("w1_avg", int'(rate_avg), 4);
    check("w1_sat", int'(saturated), 0);

    // Window 2: 2 spikes. The switch to 30 takes effect on window 3.
    for (int j = 0; j < 10; j++) drive(1'b1, 1'b1, 30, (j == 1) || (j == 5));
    check("w2_rate", int'(rate), 2);
    check("w2_avg", int'(rate_avg), 3);

    // Window 3: 30 cycles, 12 spikes.
    for (int j = 0; j < 30; j++) drive(1'b1, 1'b1, 40, ((j % 2) == 0) && (j <= 22));
    check("w3_rate", int'(rate), 12);
    check("w3_avg", int'(rate_avg), 5);

    // Window 4: 40 cycles with a spike on every other cycle (20 edges).
    for (int j = 0; j < 40; j++) drive(1'b1, 1'b1, 10, (j % 2) == 0);
    check("w4_rate", int'(rate), 15);
    check("w4_sat", int'(saturated), 1);
    check("w4_avg", int'(rate_avg), 7);

    // Window 5: 3 spikes clears saturation.
    for (int j = 0; j < 10; j++) drive(1'b1, 1'b1, 20, (j == 2) || (j == 4) || (j == 6));
    check("w5_rate", int'(rate), 3);
    check("w5_sat", int'(saturated), 0);
    check("w5_avg", int'(rate_avg), 6);

    // Window 6: abort on window cycle 8 after 3 spikes.
    for (int j = 0; j < 8; j++) drive(1'b1, 1'b1, 20, (j == 1) || (j == 3) || (j == 5));
    drive(1'b1, 1'b0, 20, 1'b0);
    check("abort_busy", int'(busy), 0);
    check("abort_valid", int'(rate_valid), 0);
    check("abort_rate_held", int'(rate), 3);
    check("abort_avg_held", int'(rate_avg), 6);
    drive(1'b1, 1'b0, 20, 1'b0);
    drive(1'b1, 1'b0, 20, 1'b0);

    // Fresh window after re-enable. window_len drops to 0 so it ends in IDLE.
    drive(1'b1, 1'b1, 5, 1'b0);
    for (int j = 0; j < 5; j++) drive(1'b1, 1'b1, 0, (j == 0) || (j == 2));
    check("w7_rate", int'(rate), 2);
    check("w7_avg", int'(rate_avg), 5);

    // window_len = 0 with ena high stays idle.
    for (int j = 0; j < 5; j++) drive(1'b1, 1'b1, 0, 1'b0);
    check("wl0_busy", int'(busy), 0);

    // window_len = 1: a strobe every cycle, rate alternates 1, 0.
    drive(1'b1, 1'b1, 1, 1'b0);
    for (int j = 0; j < 10; j++) begin
      drive(1'b1, 1'b1, 1, (j % 2) == 0);
      check("wl1_valid", int'(rate_valid), 1);
      check("wl1_rate", int'(rate), ((j % 2) == 0) ? 1 : 0);
    end
    drive(1'b1, 1'b0, 1, 1'b0);

    // Randomized phase with occasional resets and window length changes.
    wl_r = 5;
    for (int i = 0; i < 2000; i++) begin
      r_r = ($urandom_range(0, 299) != 0);
      e_r = ($urandom_range(0, 24) != 0);
      if ($urandom_range(0, 29) == 0) begin
        wl_r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40))
                                           : int'($urandom_range(0, 6));
      end
      drive(r_r, e_r, wl_r, $urandom_range(0, 1) == 1);
    end

    // Drain: no strobe may still be outstanding.
    for (int j = 0; j < 10; j++) drive(1'b1, 1'b0, 0, 1'b0);
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
